// File: rtl/vi_pkg.sv
// Shared widths and types for the vi core integer register file and its scoreboard.
package vi_pkg;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int REG_AW = $clog2(NREGS);

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]   xdata_t;

    // Width of a pending-write counter able to hold 0..max_pend.
    function automatic int cnt_width(input int max_pend);
        return $clog2(max_pend + 1);
    endfunction

endpackage

// File: rtl/vi_sb_counter.sv
// Saturating up/down pending-write counter with synchronous clear, one per architectural register.
module vi_sb_counter #(
    parameter int PW       = 2,
    parameter int MAX_PEND = 3
) (
    input  logic          clk,
    input  logic          rsn,
    input  logic          inc,
    input  logic          dec,
    input  logic          clr,
    output logic [PW-1:0] cnt
);

    localparam logic [PW-1:0] CNT_MAX = PW'(MAX_PEND);

    // NOTE: state is updated with non-blocking assignments so every counter samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rsn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !dec && cnt != CNT_MAX) begin
            cnt <= cnt + PW'(1);
        end else if (dec && !inc && cnt != '0) begin
            cnt <= cnt - PW'(1);
        end
    end

endmodule

// File: rtl/vi_int_regfile_sb.sv
// Integer register file with write-through read ports and a per-register write-pending scoreboard
// used by decode to detect RAW/WAW hazards against writes still in flight to writeback.
module vi_int_regfile_sb #(
    parameter  int XLEN     = vi_pkg::XLEN,
    parameter  int NREGS    = vi_pkg::NREGS,
    parameter  int NRD      = 2,
    parameter  int MAX_PEND = 3,
    localparam int AW       = $clog2(NREGS),
    localparam int PW       = vi_pkg::cnt_width(MAX_PEND)
) (
    input  logic                clk_i,
    input  logic                rsn_i,
    input  logic [NRD*AW-1:0]   rd_addr_i,
    output logic [NRD*XLEN-1:0] rd_data_o,
    output logic [NRD-1:0]      rd_busy_o,
    input  logic                alloc_en_i,
    input  logic [AW-1:0]       alloc_addr_i,
    output logic                alloc_ready_o,
    input  logic                wr_en_i,
    input  logic [AW-1:0]       wr_addr_i,
    input  logic [XLEN-1:0]     wr_data_i,
    input  logic                flush_i,
    output logic [NREGS-1:0]    busy_mask_o,
    output logic                underflow_err_o
);

    logic [XLEN-1:0]  regs [1:NREGS-1];
    logic [PW-1:0]    cnt  [NREGS];
    logic [NREGS-1:1] inc;
    logic [NREGS-1:1] dec;
    logic [PW-1:0]    alloc_cnt;
    logic             alloc_fire;
    logic             all_idle;
    logic             underflow;
    logic             flush_seen;
    logic             underflow_err;

    assign cnt[0] = '0;

    assign alloc_cnt     = cnt[alloc_addr_i];
    assign alloc_ready_o = (alloc_addr_i == '0) || (alloc_cnt != PW'(MAX_PEND)) ||
                           (wr_en_i && wr_addr_i == alloc_addr_i && alloc_cnt != '0);
    assign alloc_fire    = alloc_en_i && alloc_ready_o && alloc_addr_i != '0 && !flush_i;

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        inc         = '0;
        dec         = '0;
        busy_mask_o = '0;
        for (int r = 1; r < NREGS; r++) begin
            inc[r]         = alloc_fire && alloc_addr_i == AW'(r);
            dec[r]         = wr_en_i && wr_addr_i == AW'(r) && cnt[r] != '0;
            busy_mask_o[r] = cnt[r] != '0;
        end
    end

    for (genvar r = 1; r < NREGS; r++) begin : g_cnt
        vi_sb_counter #(
            .PW       (PW),
            .MAX_PEND (MAX_PEND)
        ) u_cnt (
            .clk (clk_i),
            .rsn (rsn_i),
            .inc (inc[r]),
            .dec (dec[r]),
            .clr (flush_i),
            .cnt (cnt[r])
        );
    end

    // A retiring write releases the hazard in the same cycle it is bypassed to the reader.
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] addr;
        logic [PW-1:0] rd_cnt;
        logic          wr_match;
        logic          hit;

        assign addr     = rd_addr_i[k*AW +: AW];
        assign rd_cnt   = cnt[addr];
        assign wr_match = wr_en_i && wr_addr_i == addr;
        assign hit      = wr_match && rd_cnt != '0;
        assign rd_busy_o[k] = (rd_cnt - PW'(hit)) != '0;
        assign rd_data_o[k*XLEN +: XLEN] = (addr == '0) ? '0 :
                                           wr_match     ? wr_data_i : regs[addr];
    end

    assign all_idle  = busy_mask_o == '0;
    assign underflow = wr_en_i && wr_addr_i != '0 && cnt[wr_addr_i] == '0 &&
                       !flush_i && !flush_seen;

    // flush_seen excuses straggler writes from flushed instructions until decode issues again
    // into a fully drained scoreboard.
    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            // NOTE: storage is reset too, since a never-written register must read as 0.
            for (int r = 1; r < NREGS; r++) begin
                regs[r] <= '0;
            end
            flush_seen    <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            if (wr_en_i && wr_addr_i != '0) begin
                regs[wr_addr_i] <= wr_data_i;
            end
            if (underflow) begin
                underflow_err <= 1'b1;
            end
            if (flush_i) begin
                flush_seen <= 1'b1;
            end else if (all_idle && !wr_en_i && alloc_fire) begin
                flush_seen <= 1'b0;
            end
        end
    end

    assign underflow_err_o = underflow_err;

endmodule

// File: tb/tb_vi_int_regfile_sb.sv
// Self-checking bench for vi_int_regfile_sb: directed scenarios plus randomized traffic against a
// behavioural model of the register file and scoreboard.
module tb_vi_int_regfile_sb;

    localparam int XLEN     = 32;
    localparam int NREGS    = 32;
    localparam int NRD      = 2;
    localparam int MAX_PEND = 3;
    localparam int AW       = 5;

    logic                clk = 1'b0;
    logic                rsn_i;
    logic [NRD*AW-1:0]   rd_addr_i;
    logic [NRD*XLEN-1:0] rd_data_o;
    logic [NRD-1:0]      rd_busy_o;
    logic                alloc_en_i;
    logic [AW-1:0]       alloc_addr_i;
    logic                alloc_ready_o;
    logic                wr_en_i;
    logic [AW-1:0]       wr_addr_i;
    logic [XLEN-1:0]     wr_data_i;
    logic                flush_i;
    logic [NREGS-1:0]    busy_mask_o;
    logic                underflow_err_o;

    int n_checks = 0;
    int n_fail   = 0;

    int              cnt_m  [NREGS];
    logic [XLEN-1:0] regs_m [NREGS];
    bit              fseen_m;
    bit              err_m;

    always #5 clk = ~clk;

    vi_int_regfile_sb #(
        .XLEN     (XLEN),
        .NREGS    (NREGS),
        .NRD      (NRD),
        .MAX_PEND (MAX_PEND)
    ) dut (
        .clk_i           (clk),
        .rsn_i           (rsn_i),
        .rd_addr_i       (rd_addr_i),
        .rd_data_o       (rd_data_o),
        .rd_busy_o       (rd_busy_o),
        .alloc_en_i      (alloc_en_i),
        .alloc_addr_i    (alloc_addr_i),
        .alloc_ready_o   (alloc_ready_o),
        .wr_en_i         (wr_en_i),
        .wr_addr_i       (wr_addr_i),
        .wr_data_i       (wr_data_i),
        .flush_i         (flush_i),
        .busy_mask_o     (busy_mask_o),
        .underflow_err_o (underflow_err_o)
    );

    task automatic set_rd(input int k, input int a);
        rd_addr_i[k*AW +: AW] = AW'(a);
    endtask

    function automatic logic [XLEN-1:0] rd_port(input int k);
        return rd_data_o[k*XLEN +: XLEN];
    endfunction

    function automatic int rd_addr_of(input int k);
        return int'(rd_addr_i[k*AW +: AW]);
    endfunction

    // Reference model: what each register reads as and whether it is still awaiting a write.
    function automatic logic [XLEN-1:0] exp_data(input int a);
        if (a == 0) return '0;
        if (wr_en_i && int'(wr_addr_i) == a) return wr_data_i;
        return regs_m[a];
    endfunction

    function automatic bit exp_busy(input int a);
        int retiring;
        retiring = (wr_en_i && int'(wr_addr_i) == a && cnt_m[a] > 0) ? 1 : 0;
        return (cnt_m[a] - retiring) != 0;
    endfunction

    function automatic bit exp_ready();
        int a;
        a = int'(alloc_addr_i);
        return a == 0 || cnt_m[a] != MAX_PEND ||
               (wr_en_i && int'(wr_addr_i) == a && cnt_m[a] > 0);
    endfunction

    function automatic logic [NREGS-1:0] exp_mask();
        logic [NREGS-1:0] m;
        for (int r = 0; r < NREGS; r++) m[r] = cnt_m[r] != 0;
        return m;
    endfunction

    // Advance one clock edge, updating the model from the inputs presented during the cycle.
    task automatic tick();
        int              nc [NREGS];
        logic [XLEN-1:0] nr [NREGS];
        bit              nf, ne, fire, all0;
        int              wa, aa;
        nc = cnt_m;
        nr = regs_m;
        nf = fseen_m;
        ne = err_m;
        wa = int'(wr_addr_i);
        aa = int'(alloc_addr_i);
        if (!rsn_i) begin
            for (int r = 0; r < NREGS; r++) begin
                nc[r] = 0;
                nr[r] = '0;
            end
            nf = 0;
            ne = 0;
        end else begin
            fire = alloc_en_i && exp_ready() && aa != 0 && !flush_i;
            all0 = 1;
            for (int r = 0; r < NREGS; r++) if (cnt_m[r] != 0) all0 = 0;
            if (wr_en_i && wa != 0 && cnt_m[wa] == 0 && !flush_i && !fseen_m) ne = 1;
            if (flush_i) nf = 1;
            else if (all0 && !wr_en_i && fire) nf = 0;
            if (flush_i) begin
                for (int r = 0; r < NREGS; r++) nc[r] = 0;
            end else begin
                if (fire) nc[aa] = nc[aa] + 1;
                if (wr_en_i && wa != 0 && cnt_m[wa] > 0) nc[wa] = nc[wa] - 1;
                for (int r = 0; r < NREGS; r++) begin
                    if (nc[r] > MAX_PEND) nc[r] = MAX_PEND;
                    if (nc[r] < 0) nc[r] = 0;
                end
            end
            if (wr_en_i && wa != 0) nr[wa] = wr_data_i;
        end
        @(posedge clk);
        #1;
        cnt_m   = nc;
        regs_m  = nr;
        fseen_m = nf;
        err_m   = ne;
    endtask

    task automatic idle_inputs();
        alloc_en_i = 1'b0;
        wr_en_i    = 1'b0;
        flush_i    = 1'b0;
        wr_data_i  = '0;
    endtask

    task automatic test_reset();
        rsn_i = 1'b0;
        wr_en_i = 1'b1; wr_addr_i = 5'd5; wr_data_i = 32'h1234_5678;
        alloc_en_i = 1'b1; alloc_addr_i = 5'd7; flush_i = 1'b0;
        tick();
        tick();
        rsn_i = 1'b1;
        idle_inputs();
        set_rd(0, 5); set_rd(1, 1);
        #2;
        n_checks++; if (rd_port(0) !== 32'h0) begin n_fail++; $display("FAIL reset_rd0 got=%h exp=0", rd_port(0)); end
        n_checks++; if (rd_port(1) !== 32'h0) begin n_fail++; $display("FAIL reset_rd1 got=%h exp=0", rd_port(1)); end
        n_checks++; if (rd_busy_o !== 2'b00) begin n_fail++; $display("FAIL reset_busy got=%b exp=00", rd_busy_o); end
        n_checks++; if (busy_mask_o !== '0) begin n_fail++; $display("FAIL reset_mask got=%h exp=0", busy_mask_o); end
        n_checks++; if (underflow_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", underflow_err_o); end
        n_checks++; if (alloc_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", alloc_ready_o); end
    endtask

    task automatic test_x0_underflow();
        alloc_en_i = 1'b1; alloc_addr_i = 5'd0;
        wr_en_i = 1'b1; wr_addr_i = 5'd0; wr_data_i = 32'hFFFF_FFFF;
        set_rd(0, 0); set_rd(1, 0);
        #2;
        n_checks++; if (rd_port(0) !== 32'h0) begin n_fail++; $display("FAIL x0_bypass got=%h exp=0", rd_port(0)); end
        n_checks++; if (rd_busy_o[0] !== 1'b0) begin n_fail++; $display("FAIL x0_busy got=%b exp=0", rd_busy_o[0]); end
        n_checks++; if (alloc_ready_o !== 1'b1) begin n_fail++; $display("FAIL x0_ready got=%b exp=1", alloc_ready_o); end
        tick();
        idle_inputs();
        #2;
        n_checks++; if (rd_port(1) !== 32'h0) begin n_fail++; $display("FAIL x0_stored got=%h exp=0", rd_port(1)); end
        n_checks++; if (busy_mask_o !== '0) begin n_fail++; $display("FAIL x0_mask got=%h exp=0", busy_mask_o); end
        n_checks++; if (underflow_err_o !== 1'b0) begin n_fail++; $display("FAIL x0_err got=%b exp=0", underflow_err_o); end
        wr_en_i = 1'b1; wr_addr_i = 5'd6; wr_data_i = 32'h0000_0606;
        tick();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            #2;
            n_checks++; if (underflow_err_o !== 1'b1) begin n_fail++; $display("FAIL uf_sticky%0d got=%b exp=1", i, underflow_err_o); end
            tick();
        end
    endtask

    task automatic test_bypass();
        wr_en_i = 1'b1; wr_addr_i = 5'd5; wr_data_i = 32'hDEAD_BEEF;
        set_rd(0, 6); set_rd(1, 5);
        #2;
        n_checks++; if (rd_port(1) !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL bypass_same got=%h exp=deadbeef", rd_port(1)); end
        n_checks++; if (rd_port(0) !== 32'h0000_0606) begin n_fail++; $display("FAIL bypass_other got=%h exp=00000606", rd_port(0)); end
        tick();
        idle_inputs();
        #2;
        n_checks++; if (rd_port(1) !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL bypass_stored got=%h exp=deadbeef", rd_port(1)); end
    endtask

    task automatic test_scoreboard();
        set_rd(0, 7);
        alloc_en_i = 1'b1; alloc_addr_i = 5'd7;
        for (int i = 0; i < MAX_PEND; i++) begin
            #2;
            n_checks++; if (alloc_ready_o !== 1'b1) begin n_fail++; $display("FAIL sb_ready%0d got=%b exp=1", i, alloc_ready_o); end
            tick();
        end
        #2;
        n_checks++; if (alloc_ready_o !== 1'b0) begin n_fail++; $display("FAIL sb_full got=%b exp=0", alloc_ready_o); end
        n_checks++; if (rd_busy_o[0] !== 1'b1) begin n_fail++; $display("FAIL sb_busy got=%b exp=1", rd_busy_o[0]); end
        tick();
        #2;
        n_checks++; if (alloc_ready_o !== 1'b0) begin n_fail++; $display("FAIL sb_dropped got=%b exp=0", alloc_ready_o); end
        wr_en_i = 1'b1; wr_addr_i = 5'd7; wr_data_i = 32'h0000_0077;
        #2;
        n_checks++; if (alloc_ready_o !== 1'b1) begin n_fail++; $display("FAIL sb_swap_ready got=%b exp=1", alloc_ready_o); end
        tick();
        alloc_en_i = 1'b0; wr_en_i = 1'b0;
        #2;
        n_checks++; if (alloc_ready_o !== 1'b0) begin n_fail++; $display("FAIL sb_still_full got=%b exp=0", alloc_ready_o); end
        wr_en_i = 1'b1;
        for (int i = 0; i < MAX_PEND; i++) tick();
        wr_en_i = 1'b0;
        #2;
        n_checks++; if (busy_mask_o[7] !== 1'b0) begin n_fail++; $display("FAIL sb_drained got=%b exp=0", busy_mask_o[7]); end
        n_checks++; if (alloc_ready_o !== 1'b1) begin n_fail++; $display("FAIL sb_ready_again got=%b exp=1", alloc_ready_o); end
    endtask

    task automatic test_busy_release();
        alloc_en_i = 1'b1; alloc_addr_i = 5'd3;
        tick();
        alloc_en_i = 1'b0;
        set_rd(0, 3);
        #2;
        n_checks++; if (rd_busy_o[0] !== 1'b1) begin n_fail++; $display("FAIL rel_busy got=%b exp=1", rd_busy_o[0]); end
        n_checks++; if (busy_mask_o[3] !== 1'b1) begin n_fail++; $display("FAIL rel_mask_set got=%b exp=1", busy_mask_o[3]); end
        wr_en_i = 1'b1; wr_addr_i = 5'd3; wr_data_i = 32'h3333_0003;
        #2;
        n_checks++; if (rd_busy_o[0] !== 1'b0) begin n_fail++; $display("FAIL rel_release got=%b exp=0", rd_busy_o[0]); end
        n_checks++; if (rd_port(0) !== 32'h3333_0003) begin n_fail++; $display("FAIL rel_data got=%h exp=33330003", rd_port(0)); end
        tick();
        idle_inputs();
        #2;
        n_checks++; if (busy_mask_o[3] !== 1'b0) begin n_fail++; $display("FAIL rel_mask_clr got=%b exp=0", busy_mask_o[3]); end
    endtask

    task automatic test_flush();
        alloc_en_i = 1'b1; alloc_addr_i = 5'd2;
        tick();
        tick();
        alloc_addr_i = 5'd9;
        tick();
        alloc_en_i = 1'b0;
        #2;
        n_checks++; if (busy_mask_o !== 32'h0000_0204) begin n_fail++; $display("FAIL fl_before got=%h exp=00000204", busy_mask_o); end
        flush_i = 1'b1; alloc_en_i = 1'b1; alloc_addr_i = 5'd4;
        tick();
        idle_inputs();
        set_rd(0, 4); set_rd(1, 2);
        #2;
        n_checks++; if (busy_mask_o !== '0) begin n_fail++; $display("FAIL fl_cleared got=%h exp=0", busy_mask_o); end
        n_checks++; if (rd_busy_o !== 2'b00) begin n_fail++; $display("FAIL fl_busy got=%b exp=00", rd_busy_o); end
        wr_en_i = 1'b1; wr_addr_i = 5'd2; wr_data_i = 32'h0000_2222;
        tick();
        idle_inputs();
        #2;
        n_checks++; if (underflow_err_o !== 1'b0) begin n_fail++; $display("FAIL fl_straggler_err got=%b exp=0", underflow_err_o); end
        n_checks++; if (rd_port(1) !== 32'h0000_2222) begin n_fail++; $display("FAIL fl_straggler_data got=%h exp=00002222", rd_port(1)); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rsn_i        = $urandom_range(0, 99) != 0;
            flush_i      = $urandom_range(0, 29) == 0;
            alloc_en_i   = $urandom_range(0, 1) == 1;
            alloc_addr_i = AW'($urandom_range(0, 7));
            wr_en_i      = $urandom_range(0, 2) != 0;
            wr_addr_i    = AW'($urandom_range(0, 7));
            wr_data_i    = $urandom;
            set_rd(0, $urandom_range(0, 7));
            set_rd(1, $urandom_range(0, 7));
            #2;
            for (int k = 0; k < NRD; k++) begin
                n_checks++;
                if (rd_port(k) !== exp_data(rd_addr_of(k))) begin
                    n_fail++;
                    $display("FAIL rnd_data c%0d p%0d got=%h exp=%h", i, k, rd_port(k), exp_data(rd_addr_of(k)));
                end
                n_checks++;
                if (rd_busy_o[k] !== exp_busy(rd_addr_of(k))) begin
                    n_fail++;
                    $display("FAIL rnd_busy c%0d p%0d got=%b exp=%b", i, k, rd_busy_o[k], exp_busy(rd_addr_of(k)));
                end
            end
            n_checks++; if (alloc_ready_o !== exp_ready()) begin n_fail++; $display("FAIL rnd_ready c%0d got=%b exp=%b", i, alloc_ready_o, exp_ready()); end
            n_checks++; if (busy_mask_o !== exp_mask()) begin n_fail++; $display("FAIL rnd_mask c%0d got=%h exp=%h", i, busy_mask_o, exp_mask()); end
            n_checks++; if (underflow_err_o !== err_m) begin n_fail++; $display("FAIL rnd_err c%0d got=%b exp=%b", i, underflow_err_o, err_m); end
            tick();
        end
        rsn_i = 1'b1;
        idle_inputs();
    endtask

    initial begin
        rsn_i = 1'b0;
        rd_addr_i = '0;
        alloc_addr_i = '0;
        wr_addr_i = '0;
        idle_inputs();
        test_reset();
        test_x0_underflow();
        test_bypass();
        test_scoreboard();
        test_busy_release();
        test_reset();
        test_flush();
        test_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
